// File: rtl/dyt_mem_arbiter_pkg.sv
// Shared types for the memory arbiter: word type, arbiter state encoding and grant owner.
// States use plain localparams so older tools and netlists keep the same encoding.
package dyt_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t ACCESS = 2'd1;
    localparam arb_state_t RESP   = 2'd2;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/dyt_sram_if.sv
// Bundle between the arbiter and the single-port SRAM.
// The cpu side drives address, write data and strobes; the sram side returns read data.
interface dyt_sram_if;
    import dyt_mem_arbiter_pkg::*;

    word_t sram_address;
    word_t sram_w_data;
    word_t sram_r_data;
    logic  sram_ren;
    logic  sram_wen;

    modport cpu (
        output sram_address,
        output sram_w_data,
        output sram_ren,
        output sram_wen,
        input  sram_r_data
    );

    modport sram (
        input  sram_address,
        input  sram_w_data,
        input  sram_ren,
        input  sram_wen,
        output sram_r_data
    );

endinterface

// File: rtl/dyt_mem_arbiter.sv
// Single-port SRAM arbiter: one access at a time, data port has fixed priority over fetch.
// Every output is a function of registered state, except loads which pass sram_r_data through.
module dyt_mem_arbiter
    import dyt_mem_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic           iren,
    input  word_t          iaddr,
    output logic           ihit,
    output word_t          iload,
    input  logic           dren,
    input  logic           dwen,
    input  word_t          daddr,
    input  word_t          dstore,
    output logic           dhit,
    output word_t          dload,
    dyt_sram_if.cpu        msif
);

    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    arb_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    arb_grant_t grant_q, grant_d;
    logic       wr_q, wr_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // Write wins when dwen and dren arrive together.
                if (dwen || dren) begin
                    grant_d = DATA;
                    wr_d    = dwen;
                    addr_d  = daddr;
                    wdata_d = dstore;
                    cnt_d   = 2'd0;
                    state_d = ACCESS;
                end else if (iren) begin
                    grant_d = INSTR;
                    wr_d    = 1'b0;
                    addr_d  = iaddr;
                    cnt_d   = 2'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            grant_q <= INSTR;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign msif.sram_address = addr_q;
    assign msif.sram_w_data  = wdata_q;
    assign msif.sram_wen     = (state_q == ACCESS) && wr_q;
    assign msif.sram_ren     = (state_q == ACCESS) && !wr_q;

    assign ihit  = (state_q == RESP) && (grant_q == INSTR);
    assign dhit  = (state_q == RESP) && (grant_q == DATA);
    assign iload = ihit ? msif.sram_r_data : '0;
    assign dload = (dhit && !wr_q) ? msif.sram_r_data : '0;

endmodule
